// File: rtl/keypad_matrix_scanner.sv
// Generic first-word-fall-through FIFO for small event queues.
// Latency: a write is visible at rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy drops when full unless a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign do_rd  = rd_vld && rd_rdy;
  // When full the FIFO is non-empty, so rd_rdy alone means a slot frees this cycle.
  assign wr_rdy = (count != (AW+1)'(DEPTH)) || rd_rdy;
  assign do_wr  = wr_vld && wr_rdy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

// 4x4 keypad scanner: column drive, row sampling, per-key debounce, event queue.
// Latency: key_state flips on its processing cycle; the event reaches the FIFO head one cycle later.
// Backpressure: evt_valid/evt_ready; a full FIFO drops new events and sets sticky evt_overflow.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV  = 4800,
  parameter int DEB_SCANS = 8,
  parameter int EVT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [3:0]  col_oe,
  input  logic [3:0]  row_in,
  output logic [15:0] key_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_press,
  output logic        evt_overflow
);
  localparam int CW = $clog2(SCAN_DIV);

  logic          active;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    col;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [3:0]    sample;
  logic [3:0]    deb_cnt [16];
  logic          proc_en;
  logic [1:0]    proc_row;
  logic [3:0]    proc_key;
  logic          differ;
  logic          fire;
  logic          push_rdy;

  // active holds col_oe off for the first cycle so the first slot is a full SCAN_DIV long.
  assign col_oe   = active ? (4'b0001 << col) : 4'b0000;
  assign proc_en  = active && (slot_cnt >= CW'(SCAN_DIV - 4));
  assign proc_row = 2'(slot_cnt - CW'(SCAN_DIV - 4));
  assign proc_key = {col, proc_row};
  assign differ   = sample[proc_row] != key_state[proc_key];
  assign fire     = proc_en && differ && (deb_cnt[proc_key] == 4'(DEB_SCANS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active       <= 1'b0;
      slot_cnt     <= '0;
      col          <= 2'd0;
      row_meta     <= 4'hF;
      row_sync     <= 4'hF;
      sample       <= 4'h0;
      key_state    <= 16'h0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < 16; i++) deb_cnt[i] <= 4'd0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      active   <= 1'b1;
      if (active) begin
        if (slot_cnt == CW'(SCAN_DIV - 1)) begin
          slot_cnt <= '0;
          col      <= col + 2'd1;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end
      if (active && (slot_cnt == CW'(SCAN_DIV - 5))) sample <= ~row_sync;
      if (proc_en) begin
        if (!differ) begin
          deb_cnt[proc_key] <= 4'd0;
        end else if (fire) begin
          key_state[proc_key] <= ~key_state[proc_key];
          deb_cnt[proc_key]   <= 4'd0;
        end else begin
          deb_cnt[proc_key] <= deb_cnt[proc_key] + 4'd1;
        end
      end
      if (fire && !push_rdy) evt_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W    (5),
    .DEPTH(EVT_DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .resetn(resetn),
    .wr_vld(fire),
    .wr_dat({proc_key, ~key_state[proc_key]}),
    .wr_rdy(push_rdy),
    .rd_vld(evt_valid),
    .rd_dat({evt_key, evt_press}),
    .rd_rdy(evt_ready)
  );
endmodule
